// File: rtl/par_fifo_buffer.sv
// Circular FIFO that pushes PAR_WRITE words and pops PAR_READ words per accepted request, with show-ahead output.
// Optional sticky overflow/underflow outputs are enabled by defining PAR_FIFO_ERR_FLAG_EN.
module par_fifo_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0]  din,
  input  logic                             ren,
  output logic [PAR_READ*DATA_WIDTH-1:0]   dout,
  output logic                             full,
  output logic                             empty,
  output logic [CNT_WIDTH-1:0]             count
`ifdef PAR_FIFO_ERR_FLAG_EN
  ,
  output logic                             overflow,
  output logic                             underflow
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wp;
  logic [PTR_W-1:0]      rp;
  logic [PTR_W-1:0]      wr_idx [PAR_WRITE];
  logic [PTR_W-1:0]      rd_idx [PAR_READ];
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Offsets never exceed DEPTH, so a single conditional subtract is an exact modulo.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    logic [31:0] s;
    s = 32'(base) + off;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign full  = (count > CNT_WIDTH'(DEPTH - PAR_WRITE));
  assign empty = (count < CNT_WIDTH'(PAR_READ));
  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

  always_comb begin
    for (int unsigned k = 0; k < PAR_WRITE; k++) wr_idx[k] = wrap_add(wp, k);
    for (int unsigned k = 0; k < PAR_READ; k++)  rd_idx[k] = wrap_add(rp, k);
  end

  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < PAR_READ; k++)
      dout[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx[k]];
  end

  always_comb begin
    count_nxt = count;
    if (wr_ok) count_nxt = count_nxt + CNT_WIDTH'(PAR_WRITE);
    if (rd_ok) count_nxt = count_nxt - CNT_WIDTH'(PAR_READ);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int unsigned k = 0; k < PAR_WRITE; k++)
        mem[wr_idx[k]] <= din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wrap_add(wp, PAR_WRITE);
      if (rd_ok) rp <= wrap_add(rp, PAR_READ);
      count <= count_nxt;
    end
  end

`ifdef PAR_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && full)  overflow  <= 1'b1;
      if (ren && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_par_fifo_buffer.sv
// Bench for par_fifo_buffer: three parameterisations checked against per-instance word queues,
// plus directed scenarios with literal expectations.
module tb_par_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wen = '0;
  logic [2:0]  ren = '0;
  logic [47:0] din_v [3];
  logic [15:0] dout_a;
  logic [47:0] dout_b;
  logic [31:0] dout_c;
  logic [2:0]  full_v, empty_v;
  logic [6:0]  count_a;
  logic [3:0]  count_b, count_c;
`ifdef PAR_FIFO_ERR_FLAG_EN
  logic [2:0]  ovf_v, unf_v;
`endif

  logic [15:0] q [3][$];
  bit   [2:0]  ovf_m, unf_m;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  par_fifo_buffer #(.DATA_WIDTH(16), .DEPTH(64), .PAR_WRITE(1), .PAR_READ(1)) u_a (
    .clk(clk), .rst(rst), .wen(wen[0]), .din(din_v[0][15:0]), .ren(ren[0]),
    .dout(dout_a), .full(full_v[0]), .empty(empty_v[0]), .count(count_a)
`ifdef PAR_FIFO_ERR_FLAG_EN
    , .overflow(ovf_v[0]), .underflow(unf_v[0])
`endif
  );

  par_fifo_buffer #(.DATA_WIDTH(16), .DEPTH(12), .PAR_WRITE(2), .PAR_READ(3)) u_b (
    .clk(clk), .rst(rst), .wen(wen[1]), .din(din_v[1][31:0]), .ren(ren[1]),
    .dout(dout_b), .full(full_v[1]), .empty(empty_v[1]), .count(count_b)
`ifdef PAR_FIFO_ERR_FLAG_EN
    , .overflow(ovf_v[1]), .underflow(unf_v[1])
`endif
  );

  par_fifo_buffer #(.DATA_WIDTH(16), .DEPTH(10), .PAR_WRITE(3), .PAR_READ(2)) u_c (
    .clk(clk), .rst(rst), .wen(wen[2]), .din(din_v[2][47:0]), .ren(ren[2]),
    .dout(dout_c), .full(full_v[2]), .empty(empty_v[2]), .count(count_c)
`ifdef PAR_FIFO_ERR_FLAG_EN
    , .overflow(ovf_v[2]), .underflow(unf_v[2])
`endif
  );

  function automatic int dep(input int i);
    case (i) 0: return 64; 1: return 12; default: return 10; endcase
  endfunction
  function automatic int pw(input int i);
    case (i) 0: return 1; 1: return 2; default: return 3; endcase
  endfunction
  function automatic int pr(input int i);
    case (i) 0: return 1; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int act_count(input int i);
    case (i) 0: return int'(count_a); 1: return int'(count_b); default: return int'(count_c); endcase
  endfunction
  function automatic logic [15:0] act_lane(input int i, input int k);
    case (i)
      0:       return dout_a;
      1:       return dout_b[16*k +: 16];
      default: return dout_c[16*k +: 16];
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) q[i].delete();
    ovf_m = '0;
    unf_m = '0;
  endtask

  // Reference: each FIFO is an ordered list of words; acceptance uses the pre-edge occupancy.
  task automatic model_step();
    if (rst) return;
    for (int i = 0; i < 3; i++) begin
      int sz;
      bit wa, ra;
      sz = q[i].size();
      wa = wen[i] && (sz + pw(i) <= dep(i));
      ra = ren[i] && (sz >= pr(i));
      if (wen[i] && !wa) ovf_m[i] = 1'b1;
      if (ren[i] && !ra) unf_m[i] = 1'b1;
      if (ra) for (int k = 0; k < pr(i); k++) void'(q[i].pop_front());
      if (wa) for (int k = 0; k < pw(i); k++) q[i].push_back(din_v[i][16*k +: 16]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hard_reset();
    wen = '0;
    ren = '0;
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.count", i), 64'(act_count(i)), 64'(q[i].size()));
        chk($sformatf("u%0d.full", i), 64'(full_v[i]), 64'(q[i].size() > dep(i) - pw(i)));
        chk($sformatf("u%0d.empty", i), 64'(empty_v[i]), 64'(q[i].size() < pr(i)));
        if (q[i].size() >= pr(i))
          for (int k = 0; k < pr(i); k++)
            chk($sformatf("u%0d.dout[%0d]", i, k), 64'(act_lane(i, k)), 64'(q[i][k]));
`ifdef PAR_FIFO_ERR_FLAG_EN
        chk($sformatf("u%0d.overflow", i), 64'(ovf_v[i]), 64'(ovf_m[i]));
        chk($sformatf("u%0d.underflow", i), 64'(unf_v[i]), 64'(unf_m[i]));
`endif
      end
    end
  end

  initial begin
    int wb, rb;
    for (int i = 0; i < 3; i++) din_v[i] = '0;
    clear_model();
    #1;
    chk("reset.count_a", 64'(count_a), 64'd0);
    chk("reset.empty_b", 64'(empty_v[1]), 64'd1);
    chk("reset.full_c", 64'(full_v[2]), 64'd0);

    // Test 1: fill u_a to 64, drop the 65th word, drain in order.
    hard_reset();
    for (int i = 0; i < 64; i++) begin
      wen[0] = 1'b1;
      din_v[0] = 48'(i);
      tick();
    end
    wen[0] = 1'b0;
    chk("t1.full", 64'(full_v[0]), 64'd1);
    chk("t1.count", 64'(count_a), 64'd64);
    wen[0] = 1'b1;
    din_v[0] = 48'hDEAD;
    tick();
    wen[0] = 1'b0;
    chk("t1.count_after_drop", 64'(count_a), 64'd64);
    for (int i = 0; i < 64; i++) begin
      chk("t1.dout", 64'(dout_a), 64'(i));
      ren[0] = 1'b1;
      tick();
    end
    ren[0] = 1'b0;
    chk("t1.empty", 64'(empty_v[0]), 64'd1);

    // Test 2: u_b pairs in, triples out.
    hard_reset();
    for (int i = 0; i < 6; i++) begin
      wen[1] = 1'b1;
      din_v[1] = {16'h0, 16'(2*i + 2), 16'(2*i + 1)};
      tick();
    end
    wen[1] = 1'b0;
    chk("t2.full", 64'(full_v[1]), 64'd1);
    chk("t2.count", 64'(count_b), 64'd12);
    for (int r = 0; r < 4; r++) begin
      chk("t2.dout", 64'(dout_b), {16'h0, 16'(3*r + 3), 16'(3*r + 2), 16'(3*r + 1)});
      ren[1] = 1'b1;
      tick();
    end
    ren[1] = 1'b0;
    chk("t2.empty", 64'(empty_v[1]), 64'd1);

    // Test 3: u_b with rp=wp=6, eight words wrap through index 11 -> 0.
    hard_reset();
    for (int i = 0; i < 3; i++) begin
      wen[1] = 1'b1;
      din_v[1] = 48'h1111_2222;
      tick();
    end
    wen[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ren[1] = 1'b1;
      tick();
    end
    ren[1] = 1'b0;
    chk("t3.count0", 64'(count_b), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wen[1] = 1'b1;
      din_v[1] = {16'h0, 16'(16'hA002 + 2*i), 16'(16'hA001 + 2*i)};
      tick();
    end
    wen[1] = 1'b0;
    chk("t3.count8", 64'(count_b), 64'd8);
    chk("t3.dout_abc", 64'(dout_b), 64'h0000_A003_A002_A001);
    ren[1] = 1'b1;
    tick();
    tick();
    ren[1] = 1'b0;
    chk("t3.count2", 64'(count_b), 64'd2);
    chk("t3.empty", 64'(empty_v[1]), 64'd1);
    wen[1] = 1'b1;
    din_v[1] = 48'hA00A_A009;
    tick();
    wen[1] = 1'b0;
    chk("t3.dout_wrap", 64'(dout_b), 64'h0000_A009_A008_A007);

    // Test 4: u_b at count 11 (full), simultaneous request -> only the read lands.
    hard_reset();
    for (int i = 0; i < 6; i++) begin
      wen[1] = 1'b1;
      din_v[1] = 48'($urandom);
      tick();
    end
    wen[1] = 1'b0;
    ren[1] = 1'b1;
    tick();
    ren[1] = 1'b0;
    wen[1] = 1'b1;
    tick();
    chk("t4.count11", 64'(count_b), 64'd11);
    chk("t4.full", 64'(full_v[1]), 64'd1);
    ren[1] = 1'b1;
    tick();
    wen[1] = 1'b0;
    ren[1] = 1'b0;
    chk("t4.count8", 64'(count_b), 64'd8);

    // Test 5: asynchronous reset between edges on u_a.
    hard_reset();
    for (int i = 0; i < 5; i++) begin
      wen[0] = 1'b1;
      din_v[0] = 48'(100 + i);
      tick();
    end
    wen[0] = 1'b0;
    chk("t5.count5", 64'(count_a), 64'd5);
    #1 rst = 1'b1;
    clear_model();
    #1;
    chk("t5.count_async", 64'(count_a), 64'd0);
    chk("t5.empty_async", 64'(empty_v[0]), 64'd1);
    #1 rst = 1'b0;
    wen[0] = 1'b1;
    din_v[0] = 48'hBEEF;
    tick();
    wen[0] = 1'b0;
    chk("t5.dout_new", 64'(dout_a), 64'hBEEF);
    ren[0] = 1'b1;
    tick();
    ren[0] = 1'b0;
    chk("t5.empty_end", 64'(empty_v[0]), 64'd1);

`ifdef PAR_FIFO_ERR_FLAG_EN
    // Test 6: underflow is sticky, overflow untouched.
    hard_reset();
    ren[0] = 1'b1;
    tick();
    ren[0] = 1'b0;
    chk("t6.underflow", 64'(unf_v[0]), 64'd1);
    repeat (3) tick();
    chk("t6.underflow_sticky", 64'(unf_v[0]), 64'd1);
    chk("t6.overflow", 64'(ovf_v[0]), 64'd0);
`endif

    // Random traffic on all three instances with drifting write/read bias.
    hard_reset();
    wb = 50;
    rb = 50;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 300 == 0) begin
        wb = $urandom_range(10, 90);
        rb = $urandom_range(10, 90);
      end
      for (int i = 0; i < 3; i++) begin
        wen[i] = ($urandom_range(0, 99) < wb);
        ren[i] = ($urandom_range(0, 99) < rb);
        din_v[i] = {16'($urandom), 32'($urandom)};
      end
      tick();
      if (cyc == 3000) begin
        #1 rst = 1'b1;
        clear_model();
        #1 rst = 1'b0;
      end
    end
    wen = '0;
    ren = '0;
    tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
